// File: rtl/uart_rx_data_sampler_if.sv
// Bus between the RX FSM/line side and the oversampling data sampler.
// The master drives the line, prescale and enables; the slave returns counters and the voted bit.
interface uart_rx_data_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  count_en;
  logic                  sample_en;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  sampled_bit;
  logic                  sample_done;

  modport master (
    output rx_in, prescale, count_en, sample_en,
    input  edge_count, bit_count, sampled_bit, sample_done
  );

  modport slave (
    input  rx_in, prescale, count_en, sample_en,
    output edge_count, bit_count, sampled_bit, sample_done
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampling front end: edge/bit counters plus a three-point majority vote.
// Optional macro UART_RX_SYNC_EN adds a two-flop synchronizer on rx_in.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input logic                   clk,
  input logic                   rst,
  uart_rx_data_sampler_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
  localparam logic [PRESCALE_W-1:0] P_RST = PRESCALE_W'(8);
  localparam logic [BIT_CNT_W-1:0]  B_MAX = '1;

  logic                  line;
  logic [PRESCALE_W-1:0] p_reg;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] edge_q;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic                  s0;
  logic                  s1;
  logic                  sampled_q;
  logic                  done_q;
  logic                  wrap;
  logic                  at_s0;
  logic                  at_s1;
  logic                  at_vote;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Synchronizer resets to the idle level so no false start bit appears after reset.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.rx_in};
  end

  assign line = sync_q[1];
`else
  assign line = bus.rx_in;
`endif

  always_comb begin
    half    = p_reg >> 1;
    wrap    = (edge_q == p_reg - ONE);
    at_s0   = bus.sample_en && (edge_q == half - ONE);
    at_s1   = bus.sample_en && (edge_q == half);
    at_vote = bus.sample_en && (edge_q == half + ONE);
  end

  // Prescale is only taken between frames so the bit period cannot shift mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg <= P_RST;
    end else if (!bus.count_en) begin
      p_reg <= (bus.prescale < P_MIN) ? P_MIN : bus.prescale;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (!bus.count_en) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (wrap) begin
      edge_q <= '0;
      if (bit_q != B_MAX) bit_q <= bit_q + BIT_CNT_W'(1);
    end else begin
      edge_q <= edge_q + ONE;
    end
  end

  // The vote uses the pre-clear edge count, so a sample coinciding with count_en falling still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0        <= 1'b1;
      s1        <= 1'b1;
      sampled_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (at_s0) s0 <= line;
      if (at_s1) s1 <= line;
      if (at_vote) begin
        sampled_q <= (s0 & s1) | (s0 & line) | (s1 & line);
        done_q    <= 1'b1;
      end
    end
  end

  assign bus.edge_count  = edge_q;
  assign bus.bit_count   = bit_q;
  assign bus.sampled_bit = sampled_q;
  assign bus.sample_done = done_q;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Self-checking bench for uart_rx_data_sampler: scoreboard of expected votes plus per-cycle counter checks.
`timescale 1ns/1ps
module tb_uart_rx_data_sampler;

  localparam int BIT_MAX = 15;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int value;
    int edge_pos;
    int bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_data_sampler_if bus ();

  uart_rx_data_sampler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t exp_q[$];
  exp_t mon_item;
  int   model_last   = 1;
  bit   line_buf [0:1023];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int seen(input int c);
    int j;
    j = c - LAT;
    return (j < 0) ? 1 : int'(line_buf[j]);
  endfunction

  function automatic int sat(input int x);
    return (x > BIT_MAX) ? BIT_MAX : x;
  endfunction

  // Monitor: every sample_done pulse must match the oldest expected vote.
  always @(negedge clk) begin
    if (bus.sample_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_sample_done", 1, 0);
      end else begin
        mon_item = exp_q.pop_front();
        checkOutput("sampled_bit", int'(bus.sampled_bit), mon_item.value);
        checkOutput("done_edge_count", int'(bus.edge_count), mon_item.edge_pos);
        checkOutput("done_bit_count", int'(bus.bit_count), mon_item.bits);
      end
    end
  end

  task automatic idle(input int n);
    bus.count_en  = 1'b0;
    bus.sample_en = 1'b0;
    bus.rx_in     = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs count_en high for ncycles cycles over line_buf, then one cycle with count_en low.
  task automatic applyStimulus(input int p, input int ncycles, input bit s_en, input bit mid_change);
    int h;
    exp_t it;
    h = p / 2;
    bus.prescale = 6'(p);
    idle(3);
    for (int c = 0; c <= ncycles; c++) begin
      if (s_en && (c % p) == h + 1) begin
        it.value    = ((seen(c - 2) + seen(c - 1) + seen(c)) >= 2) ? 1 : 0;
        it.edge_pos = (c < ncycles) ? (c + 1) % p : 0;
        it.bits     = (c < ncycles) ? sat((c + 1) / p) : 0;
        exp_q.push_back(it);
        model_last = it.value;
      end
    end
    for (int c = 0; c <= ncycles; c++) begin
      bus.count_en  = (c < ncycles);
      bus.sample_en = s_en;
      bus.rx_in     = line_buf[c];
      if (mid_change && c == ncycles / 2) bus.prescale = (p == 8) ? 6'd16 : 6'd8;
      @(posedge clk);
      #1;
      checkOutput("edge_count", int'(bus.edge_count), (c < ncycles) ? (c + 1) % p : 0);
      checkOutput("bit_count", int'(bus.bit_count), (c < ncycles) ? sat((c + 1) / p) : 0);
    end
    idle(3);
    checkOutput("missing_sample_done", exp_q.size(), 0);
    checkOutput("held_sampled_bit", int'(bus.sampled_bit), model_last);
  endtask

  task automatic fillBits(input int p, input int nbits, input bit glitchy);
    bit v;
    for (int k = 0; k < nbits; k++) begin
      v = 1'($urandom_range(0, 1));
      for (int i = 0; i < p; i++)
        line_buf[k * p + i] = v ^ (glitchy && $urandom_range(0, 7) == 0);
    end
    line_buf[nbits * p] = 1'b1;
  endtask

  initial begin
    int pats [9];
    int p, nbits, ncyc;
    bus.rx_in     = 1'b1;
    bus.prescale  = 6'd8;
    bus.count_en  = 1'b0;
    bus.sample_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_edge_count", int'(bus.edge_count), 0);
    checkOutput("reset_bit_count", int'(bus.bit_count), 0);
    checkOutput("reset_sampled_bit", int'(bus.sampled_bit), 1);
    checkOutput("reset_sample_done", int'(bus.sample_done), 0);
    rst = 1'b0;

    // Clean frame: start bit then 8'hA5 LSB-first at P=8.
    pats = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
    for (int k = 0; k < 9; k++)
      for (int i = 0; i < 8; i++) line_buf[k * 8 + i] = pats[k][0];
    line_buf[72] = 1'b1;
    applyStimulus(8, 72, 1'b1, 1'b0);
    checkOutput("clean_last_bit", int'(bus.sampled_bit), 1);

    // Glitch rejection at P=16: lone low at edge 8, then lows at 7 and 9.
    for (int i = 0; i <= 32; i++) line_buf[i] = 1'b1;
    line_buf[8]  = 1'b0;
    line_buf[23] = 1'b0;
    line_buf[25] = 1'b0;
    applyStimulus(16, 32, 1'b1, 1'b0);

    // Prescale changes mid-frame, then the following frame must use 16.
    fillBits(8, 4, 1'b0);
    applyStimulus(8, 32, 1'b1, 1'b1);
    fillBits(16, 3, 1'b0);
    applyStimulus(16, 48, 1'b1, 1'b0);

    // Abort with count_en low at edge 5 of bit 3: the coincident vote still completes.
    fillBits(8, 4, 1'b1);
    applyStimulus(8, 29, 1'b1, 1'b0);

    // Sampling disabled while the line toggles.
    for (int i = 0; i <= 64; i++) line_buf[i] = 1'($urandom_range(0, 1));
    line_buf[64] = 1'b1;
    applyStimulus(8, 64, 1'b0, 1'b0);

    // Randomized frames, including bit_count saturation and random aborts.
    for (int f = 0; f < 10; f++) begin
      p     = 8 << $urandom_range(0, 2);
      nbits = $urandom_range(1, 18);
      ncyc  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nbits * p) : nbits * p;
      fillBits(p, nbits, 1'b1);
      line_buf[ncyc] = 1'b1;
      applyStimulus(p, ncyc, ($urandom_range(0, 4) != 0), 1'b0);
    end

    // Reset mid-frame after a frame that left sampled_bit low.
    for (int i = 0; i < 16; i++) line_buf[i] = 1'b0;
    line_buf[16] = 1'b1;
    applyStimulus(8, 16, 1'b1, 1'b0);
    bus.prescale = 6'd8;
    idle(2);
    for (int c = 0; c < 4; c++) begin
      bus.count_en  = 1'b1;
      bus.sample_en = 1'b1;
      bus.rx_in     = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_edge_count", int'(bus.edge_count), 4);
    checkOutput("pre_reset_sampled_bit", int'(bus.sampled_bit), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_reset_edge_count", int'(bus.edge_count), 0);
    checkOutput("mid_reset_bit_count", int'(bus.bit_count), 0);
    checkOutput("mid_reset_sampled_bit", int'(bus.sampled_bit), 1);
    checkOutput("mid_reset_sample_done", int'(bus.sample_done), 0);
    rst = 1'b0;
    model_last = 1;
    idle(12);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_rx_data_sampler.md
# uart_rx_data_sampler

Oversampling front end of the UART receiver: counts prescale clock edges within each bit period, counts bit periods within a frame, and takes a three-point majority vote of the serial line around the bit centre. It sits directly upstream of the stop-bit checker and the other RX checkers. Its `edge_count` and `sampled_bit` outputs feed the stop checker, whose check fires at `edge_count == prescale/2 + 2`. The RX FSM drives its enables.

## Interface
- `PRESCALE_W`, default 6: width of `prescale` and `edge_count`; supports a prescale of up to 2^PRESCALE_W − 1.
- `BIT_CNT_W`, default 4: width of `bit_count`.

- `clk`, input, 1: receiver oversampling clock.
- `rst`, input, 1: synchronous reset, active-high.
- `rx_in`, input, 1: serial line, idle high.
- `prescale`, input, PRESCALE_W: oversampling ratio. Legal values are 8, 16 and 32.
- `count_en`, input, 1: FSM enable for the edge and bit counters.
- `sample_en`, input, 1: FSM enable for the majority sampler.
- `edge_count`, output, PRESCALE_W: position within the current bit period, 0..P−1.
- `bit_count`, output, BIT_CNT_W: index of the current bit within the frame.
- `sampled_bit`, output, 1: majority-voted value of the current bit.
- `sample_done`, output, 1: one-cycle pulse when `sampled_bit` has been updated.

## Operation
- **Prescale latch.**
  - An internal register P latches `prescale` on any cycle where `count_en` is 0.
  - P is frozen while `count_en` is 1, so a mid-frame change of `prescale` has no effect until the next frame.
  - A latched value below 4 is clamped to 4.
- **Edge counter.**
  - While `count_en` is 1, `edge_count` increments by 1 each cycle.
  - When `edge_count == P−1` it wraps to 0.
  - Any cycle with `count_en` at 0 clears `edge_count` on the next edge.
- **Bit counter.**
  - `bit_count` increments on the same cycle that `edge_count` wraps.
  - It saturates at 2^BIT_CNT_W − 1.
  - It is cleared by `count_en` being 0.
- **Sample points.** Let H = P/2, computed as P >> 1.
  - When `sample_en` is 1 and `edge_count == H−1`: store the line value in s0.
  - When `sample_en` is 1 and `edge_count == H`: store the line value in s1.
  - When `sample_en` is 1 and `edge_count == H+1`: register `sampled_bit` as maj(s0, s1, line), i.e. (s0&s1)|(s0&line)|(s1&line). On the same edge set `sample_done` to 1.
- **Sampling disabled.** When `sample_en` is 0, s0, s1 and `sampled_bit` hold their values and `sample_done` stays 0.
- **Result window.** `sampled_bit` is stable from `edge_count == H+2` until the next `H+1` update. This is the window the stop checker uses.
- **Simultaneous events.** If `count_en` falls on the same cycle as an `H+1` sample, the sample still completes, because it uses the pre-clear `edge_count`.
- **Reset.**
  - Values after reset: `edge_count`=0, `bit_count`=0, `sampled_bit`=1 (idle level), `sample_done`=0, s0=s1=1, P=8.
  - A reset mid-frame aborts the frame immediately. No pulse is emitted.

## Timing
- All outputs are registered, and all state changes occur on the rising edge of `clk`.
- Latency from the third sample point to `sampled_bit`/`sample_done`: 1 cycle. Both outputs are visible at `edge_count == H+2`.
- `sample_done` is exactly one cycle wide and occurs at most once per bit period.
- With P=8: samples are taken at `edge_count` 3, 4 and 5. `sample_done` is high during `edge_count` 6. The wrap happens from 7 to 0.
- The first count cycle after `count_en` rises shows `edge_count`=0. Counting starts at the edge where `count_en` is first sampled high.

## Configuration
- Macro `UART_RX_SYNC_EN`.
  - **Defined:** `rx_in` passes through a two-flop synchronizer, reset to 1, before all sampling. The line-to-sample latency grows by 2 cycles, with no change to counter timing.
  - **Undefined:** `rx_in` is sampled directly; this is for use when the line is already synchronous to `clk`.

## Test plan
- **Clean frame, P=8:**
  - Stimulus: `count_en`=`sample_en`=1, line driven with start bit 0 then 8'hA5 LSB-first, each bit held 8 clocks.
  - Required: `sample_done` pulses once every 8 cycles at `edge_count`=6, and `sampled_bit` follows 0,1,0,1,0,0,1,0,1.
  - Required: `bit_count` steps from 0 to 9.
- **Glitch rejection, P=16:**
  - Stimulus: line at 1 with a single-cycle 0 at `edge_count`=8.
  - Required: `sampled_bit`=1.
  - Stimulus: line 0 at both 7 and 9.
  - Required: `sampled_bit`=0.
- **Prescale change mid-frame:**
  - Stimulus: `prescale` switched from 8 to 16 while `count_en`=1.
  - Required: wrap stays at 7 until `count_en` drops, and the next frame wraps at 15.
- **Disable/clear:**
  - Stimulus: `count_en` dropped at `edge_count`=5, `bit_count`=3.
  - Required: next cycle `edge_count`=0, `bit_count`=0, `sample_done`=0 afterwards.
- **Reset mid-frame:**
  - Stimulus: `rst`=1 at `edge_count`=4.
  - Required: next cycle all outputs are at their reset values (`sampled_bit`=1) and no `sample_done` occurs.
- **Sampling disabled:**
  - Stimulus: `sample_en`=0 with `count_en`=1 and toggling `rx_in`.
  - Required: counters advance, `sampled_bit` holds, and `sample_done` stays 0.
